// File: rtl/signal_sync_multi_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel level synchroniser.
package signal_sync_multi_pkg;

    localparam int unsigned DEF_WIDTH  = 1;
    localparam int unsigned DEF_STAGES = 2;
    localparam int unsigned DEF_FILTER = 0;
    localparam int unsigned MIN_STAGES = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    // Filter counter must hold 0..FILTER and never collapse to zero bits.
    function automatic int unsigned cnt_width(input int unsigned filter);
        int unsigned w;
        w = clog2(filter + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/signal_sync_multi_chan.sv
// One synchroniser channel: async-register chain, run-length glitch filter and edge strobes.
module signal_sync_multi_chan
    import signal_sync_multi_pkg::*;
#(
    parameter int unsigned STAGES    = DEF_STAGES,
    parameter int unsigned FILTER    = DEF_FILTER,
    parameter logic        RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW      = cnt_width(FILTER);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
    logic [CW-1:0] cnt;
    logic          q;

    assign q = chain[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_BIT}};
            level <= RESET_BIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], raw};
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (q == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Disagreement has persisted for FILTER+1 edges: accept it.
                level <= q;
                cnt   <= '0;
                rise  <= q;
                fall  <= ~q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/signal_sync_multi.sv
// Multi-channel synchroniser for asynchronous level inputs into the o_clk domain.
module signal_sync_multi
    import signal_sync_multi_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      STAGES    = DEF_STAGES,
    parameter int unsigned      FILTER    = DEF_FILTER,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             o_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_signal,
    output logic [WIDTH-1:0] o_signal,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("signal_sync_multi: STAGES must be at least 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        signal_sync_multi_chan #(
            .STAGES    (STAGES),
            .FILTER    (FILTER),
            .RESET_BIT (RESET_VAL[i])
        ) u_chan (
            .clk   (o_clk),
            .rst_n (rst_n),
            .raw   (i_signal[i]),
            .level (o_signal[i]),
            .rise  (o_rise[i]),
            .fall  (o_fall[i])
        );
    end

endmodule

// File: tb/tb_signal_sync_multi.sv
// Bench for signal_sync_multi: two configurations checked against a sample-history reference model.
module tb_signal_sync_multi;

    localparam int unsigned SA  = 2;
    localparam int unsigned FA  = 3;
    localparam int unsigned SB  = 3;
    localparam int unsigned FB  = 0;
    localparam logic [3:0]  RVA = 4'h0;
    localparam logic [3:0]  RVB = 4'hA;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_a, sig_a, rise_a, fall_a;
    logic [3:0] in_b, sig_b, rise_b, fall_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: input value sampled at each edge since reset (prefilled with the reset level).
    logic [3:0] hist_a[$];
    logic [3:0] hist_b[$];
    logic [3:0] m_sig_a, m_rise_a, m_fall_a;
    logic [3:0] m_sig_b, m_rise_b, m_fall_b;

    signal_sync_multi #(.WIDTH(4), .STAGES(SA), .FILTER(FA), .RESET_VAL(RVA)) dut_a (
        .o_clk(clk), .rst_n(rst_n), .i_signal(in_a),
        .o_signal(sig_a), .o_rise(rise_a), .o_fall(fall_a)
    );

    signal_sync_multi #(.WIDTH(4), .STAGES(SB), .FILTER(FB), .RESET_VAL(RVB)) dut_b (
        .o_clk(clk), .rst_n(rst_n), .i_signal(in_b),
        .o_signal(sig_b), .o_rise(rise_b), .o_fall(fall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A channel flips when the synchronised input seen at each of the last
    // filter+1 edges differed from the current output.
    function automatic logic [3:0] accept_mask(input logic [3:0] hq[$], input int stages,
                                               input int filter, input logic [3:0] o);
        logic [3:0] m;
        int last;
        m = 4'hF;
        last = hq.size() - 1;
        for (int k = 0; k <= filter; k++) m &= hq[last - stages - k] ^ o;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sig_a"},  32'(sig_a),  32'(m_sig_a));
        check({tag, ".rise_a"}, 32'(rise_a), 32'(m_rise_a));
        check({tag, ".fall_a"}, 32'(fall_a), 32'(m_fall_a));
        check({tag, ".sig_b"},  32'(sig_b),  32'(m_sig_b));
        check({tag, ".rise_b"}, 32'(rise_b), 32'(m_rise_b));
        check({tag, ".fall_b"}, 32'(fall_b), 32'(m_fall_b));
    endtask

    task automatic reset_model();
        hist_a.delete();
        hist_b.delete();
        for (int k = 0; k <= int'(SA + FA); k++) hist_a.push_back(RVA);
        for (int k = 0; k <= int'(SB + FB); k++) hist_b.push_back(RVB);
        m_sig_a = RVA; m_rise_a = '0; m_fall_a = '0;
        m_sig_b = RVB; m_rise_b = '0; m_fall_b = '0;
    endtask

    task automatic tick(input string tag);
        logic [3:0] m;
        @(posedge clk);
        if (rst_n) begin
            hist_a.push_back(in_a);
            if (hist_a.size() > int'(SA + FA + 2)) void'(hist_a.pop_front());
            m = accept_mask(hist_a, SA, FA, m_sig_a);
            m_rise_a = m & ~m_sig_a;
            m_fall_a = m & m_sig_a;
            m_sig_a  = m_sig_a ^ m;

            hist_b.push_back(in_b);
            if (hist_b.size() > int'(SB + FB + 2)) void'(hist_b.pop_front());
            m = accept_mask(hist_b, SB, FB, m_sig_b);
            m_rise_b = m & ~m_sig_b;
            m_fall_b = m & m_sig_b;
            m_sig_b  = m_sig_b ^ m;
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        check({tag, ".sig_a"}, 32'(sig_a), 32'(RVA));
        check({tag, ".sig_b"}, 32'(sig_b), 32'(RVB));
        check_all(tag);
    endtask

    initial begin
        int rc, fc, strobes;
        logic [3:0] ma, mb;

        rst_n = 1'b1;
        in_a  = 4'hF;
        in_b  = RVB;
        reset_model();

        // Reset held with inputs opposite the reset level.
        async_reset("t1.rst");
        for (int i = 0; i < 3; i++) tick("t1.hold");
        check("t1.hold_sig", 32'(sig_a), 32'h0);

        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) tick("t1.lat");
        check("t1.pre_edge_sig", 32'(sig_a), 32'h0);
        tick("t1.lat");
        check("t1.sig_after", 32'(sig_a), 32'hF);
        check("t1.rise_after", 32'(rise_a), 32'hF);
        tick("t1.post");
        check("t1.rise_once", 32'(rise_a), 32'h0);

        // Step on ch0.
        in_a = 4'h0;
        for (int i = 0; i < 8; i++) tick("t2.settle");
        in_a[0] = 1'b1;
        rc = 0; fc = 0;
        for (int i = 0; i < 10; i++) begin
            tick("t2.high");
            rc += int'(rise_a[0]);
            fc += int'(fall_a[0]);
        end
        in_a[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick("t2.low");
            rc += int'(rise_a[0]);
            fc += int'(fall_a[0]);
        end
        check("t2.rise_count", 32'(rc), 32'd1);
        check("t2.fall_count", 32'(fc), 32'd1);

        // Glitch of 3 cycles rejected, 4 cycles accepted.
        rc = 0;
        in_a[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin tick("t3.g3"); rc += int'(rise_a[1]); end
        in_a[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick("t3.g3q"); rc += int'(rise_a[1]); end
        check("t3.short_rise", 32'(rc), 32'd0);
        check("t3.short_sig", 32'(sig_a[1]), 32'd0);
        rc = 0;
        in_a[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin tick("t3.g4"); rc += int'(rise_a[1]); end
        in_a[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick("t3.g4q"); rc += int'(rise_a[1]); end
        check("t3.long_rise", 32'(rc), 32'd1);

        // Simultaneous opposite transitions on ch2/ch3.
        in_a = 4'b1000;
        for (int i = 0; i < 10; i++) tick("t4.settle");
        in_a = 4'b0100;
        for (int i = 0; i < 5; i++) tick("t4.wait");
        tick("t4.edge");
        check("t4.rise", 32'(rise_a), 32'h4);
        check("t4.fall", 32'(fall_a), 32'h8);
        tick("t4.after");

        // Reset while ch0's filter counter is part-way through.
        in_a = 4'b1110;
        for (int i = 0; i < 10; i++) tick("t5.settle");
        in_a = 4'b1111;
        for (int i = 0; i < 4; i++) tick("t5.partial");
        async_reset("t5.rst");
        tick("t5.hold");
        tick("t5.hold");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick("t5.lat");
        check("t5.pre_edge_sig", 32'(sig_a), 32'h0);
        tick("t5.lat");
        check("t5.sig_after", 32'(sig_a), 32'hF);

        // Config B toggling every 2 cycles.
        strobes = 0;
        for (int t = 0; t < 10; t++) begin
            in_b = in_b ^ 4'hF;
            for (int i = 0; i < 2; i++) begin
                tick("t6.toggle");
                strobes += $countones(rise_b) + $countones(fall_b);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick("t6.flush");
            strobes += $countones(rise_b) + $countones(fall_b);
        end
        check("t6.strobes", 32'(strobes), 32'd40);

        // Random traffic on both configurations, with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            ma = 4'($urandom) & 4'($urandom);
            mb = 4'($urandom) & 4'($urandom);
            in_a = in_a ^ ma;
            in_b = in_b ^ mb;
            if (i == 200) begin
                async_reset("rnd.rst");
                tick("rnd.hold");
                rst_n = 1'b1;
            end
            tick("rnd");
            check("rnd.excl_a", 32'(rise_a & fall_a), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
